// File: rtl/multicycle_shift_unit.sv
// Iterative shift/rotate unit: sll/srl/sra/rol/ror on a DATA_W operand,
// at most STEP bits per cycle, with a start/busy/done handshake toward control.
module multicycle_shift_unit #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               flush,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [31:0] WIDTH_32 = 32'(DATA_W);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [2:0]          mode_q, mode_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                mode_legal;
  logic [31:0]         shamt_ext;
  logic [31:0]         eff_ext;
  logic [CNT_W-1:0]    eff_amt;
  logic [CNT_W-1:0]    step_amt;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   cand [STEP+1];

  // Clamp/wrap the requested amount so rem never exceeds what the mode can use.
  always_comb begin
    shamt_ext  = 32'(shamt);
    mode_legal = 1'b1;
    eff_ext    = 32'd0;
    case (mode)
      MODE_SLL, MODE_SRL: eff_ext = (shamt_ext > WIDTH_32) ? WIDTH_32 : shamt_ext;
      MODE_SRA:           eff_ext = (shamt_ext > WIDTH_32 - 32'd1) ? WIDTH_32 - 32'd1 : shamt_ext;
      MODE_ROL, MODE_ROR: eff_ext = shamt_ext % WIDTH_32;
      default: begin
        mode_legal = 1'b0;
        eff_ext    = 32'd0;
      end
    endcase
    eff_amt = CNT_W'(eff_ext);
  end

  function automatic logic [DATA_W-1:0] shift_const(
    input logic [DATA_W-1:0] v,
    input logic [2:0]        m,
    input int                k
  );
    logic [DATA_W-1:0] r;
    case (m)
      MODE_SLL: r = v << k;
      MODE_SRL: r = v >> k;
      MODE_SRA: r = $signed(v) >>> k;
      MODE_ROL: r = (v << k) | (v >> (DATA_W - k));
      MODE_ROR: r = (v >> k) | (v << (DATA_W - k));
      default:  r = v;
    endcase
    return r;
  endfunction

  // One fixed-distance shifter per possible step size keeps the mux bounded by STEP.
  generate
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
      assign cand[gi] = shift_const(acc_q, mode_q, gi);
    end
  endgenerate

  assign step_amt = (rem_q > STEP_C) ? STEP_C : rem_q;

  always_comb begin
    shifted = acc_q;
    for (int k = 0; k <= STEP; k++) begin
      if (step_amt == CNT_W'(k)) shifted = cand[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_d   = data_in;
            rem_d   = eff_amt;
            mode_d  = mode;
            state_d = ST_RUN;
            err_d   = ~mode_legal;
          end
        end
        ST_RUN: begin
          err_d = start;
          if (rem_q == '0) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            result_d = acc_q;
          end else begin
            acc_d = shifted;
            rem_d = rem_q - step_amt;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Directed bench for multicycle_shift_unit: three instances (STEP=1, STEP=4, SHAMT_W=5)
// driven by a linear sequence of steps with hand-computed expectations.
module tb_multicycle_shift_unit;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_ILL = 3'b110;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [2:0]  mode;
  logic [15:0] data_in;
  logic        start_a, start_b, start_c;
  logic [3:0]  shamt_a, shamt_b;
  logic [4:0]  shamt_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        err_a, err_b, err_c;
  logic [15:0] result_a, result_b, result_c;

  int n_pass  = 0;
  int n_total = 0;
  int n;
  int errs;
  int dones;

  multicycle_shift_unit #(.DATA_W(16), .SHAMT_W(4), .STEP(1)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .flush(flush), .mode(mode),
    .shamt(shamt_a), .data_in(data_in), .busy(busy_a), .done(done_a),
    .result(result_a), .err(err_a)
  );

  multicycle_shift_unit #(.DATA_W(16), .SHAMT_W(4), .STEP(4)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .flush(flush), .mode(mode),
    .shamt(shamt_b), .data_in(data_in), .busy(busy_b), .done(done_b),
    .result(result_b), .err(err_b)
  );

  multicycle_shift_unit #(.DATA_W(16), .SHAMT_W(5), .STEP(4)) u_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .flush(flush), .mode(mode),
    .shamt(shamt_c), .data_in(data_in), .busy(busy_c), .done(done_c),
    .result(result_c), .err(err_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] get_busy(input int sel);
    case (sel)
      0: return 32'(busy_a);
      1: return 32'(busy_b);
      default: return 32'(busy_c);
    endcase
  endfunction

  function automatic logic [31:0] get_done(input int sel);
    case (sel)
      0: return 32'(done_a);
      1: return 32'(done_b);
      default: return 32'(done_c);
    endcase
  endfunction

  function automatic logic [31:0] get_err(input int sel);
    case (sel)
      0: return 32'(err_a);
      1: return 32'(err_b);
      default: return 32'(err_c);
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int sel);
    case (sel)
      0: return 32'(result_a);
      1: return 32'(result_b);
      default: return 32'(result_c);
    endcase
  endfunction

  // Present one request and clock the accept edge.
  task automatic go(input int sel, input logic [2:0] m, input logic [15:0] d, input logic [4:0] sh);
    mode    = m;
    data_in = d;
    case (sel)
      0: begin start_a = 1'b1; shamt_a = sh[3:0]; end
      1: begin start_b = 1'b1; shamt_b = sh[3:0]; end
      default: begin start_c = 1'b1; shamt_c = sh; end
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Edges after the accept edge until done is seen; 40 means it never came.
  task automatic wait_done(input int sel, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (get_done(sel) == 32'd0 && cnt < 40);
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    mode    = 3'b000;
    data_in = 16'h0000;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    shamt_a = 4'd0; shamt_b = 4'd0; shamt_c = 5'd0;

    repeat (2) tick();
    check("reset_busy",   get_busy(0),   32'd0);
    check("reset_done",   get_done(0),   32'd0);
    check("reset_err",    get_err(0),    32'd0);
    check("reset_result", get_result(0), 32'd0);
    reset_n = 1'b1;
    tick();

    // sll 0x0001 by 4, one bit per cycle
    go(0, M_SLL, 16'h0001, 5'd4);
    check("sll_busy", get_busy(0), 32'd1);
    check("sll_err",  get_err(0),  32'd0);
    wait_done(0, n);
    check("sll_lat",  32'(n), 32'd5);
    check("sll_res",  get_result(0), 32'h0010);
    tick();
    check("sll_done_pulse", get_done(0), 32'd0);

    // STEP=4 arithmetic and logical right shifts, back to back
    go(1, M_SRA, 16'h8000, 5'd15);
    wait_done(1, n);
    check("sra_lat", 32'(n), 32'd5);
    check("sra_res", get_result(1), 32'hFFFF);
    go(1, M_SRL, 16'h8000, 5'd15);
    wait_done(1, n);
    check("srl_lat", 32'(n), 32'd5);
    check("srl_res", get_result(1), 32'h0001);

    // rotates
    go(1, M_ROR, 16'h1234, 5'd4);
    wait_done(1, n);
    check("ror_lat", 32'(n), 32'd2);
    check("ror_res", get_result(1), 32'h4123);
    go(0, M_ROL, 16'h8001, 5'd1);
    wait_done(0, n);
    check("rol_lat", 32'(n), 32'd2);
    check("rol_res", get_result(0), 32'h0003);

    // wide shamt: clamping and modulo
    go(2, M_SRL, 16'hFFFF, 5'd20);
    wait_done(2, n);
    check("srl20_lat", 32'(n), 32'd5);
    check("srl20_res", get_result(2), 32'h0000);
    go(2, M_ROR, 16'h1234, 5'd20);
    wait_done(2, n);
    check("ror20_lat", 32'(n), 32'd2);
    check("ror20_res", get_result(2), 32'h4123);
    go(2, M_SRA, 16'h8000, 5'd31);
    wait_done(2, n);
    check("sra31_lat", 32'(n), 32'd5);
    check("sra31_res", get_result(2), 32'hFFFF);
    go(2, M_SLL, 16'h0001, 5'd17);
    wait_done(2, n);
    check("sll17_res", get_result(2), 32'h0000);
    go(2, M_ROL, 16'hA5C3, 5'd16);
    wait_done(2, n);
    check("rol16_lat", 32'(n), 32'd1);
    check("rol16_res", get_result(2), 32'hA5C3);

    // illegal mode passes data through with an err pulse
    go(2, M_ILL, 16'hBEEF, 5'd3);
    check("ill_err", get_err(2), 32'd1);
    wait_done(2, n);
    check("ill_lat", 32'(n), 32'd1);
    check("ill_res", get_result(2), 32'hBEEF);
    check("ill_err_pulse", get_err(2), 32'd0);

    // start while busy: two err pulses, operands of the running op untouched
    go(0, M_SLL, 16'h00A5, 5'd8);
    n = 40;
    errs = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 2 || i == 4) begin
        start_a = 1'b1;
        mode    = M_SRL;
        data_in = 16'hFFFF;
        shamt_a = 4'd1;
      end
      tick();
      start_a = 1'b0;
      if (err_a) errs++;
      if (done_a) begin
        n = i;
        break;
      end
    end
    check("busy_start_errs", 32'(errs), 32'd2);
    check("busy_start_lat",  32'(n), 32'd9);
    check("busy_start_res",  get_result(0), 32'hA500);

    // new start in the done cycle is accepted on the next edge
    go(0, M_SRL, 16'hF000, 5'd4);
    check("b2b_done_single", get_done(0), 32'd0);
    check("b2b_busy",        get_busy(0), 32'd1);
    check("b2b_err",         get_err(0),  32'd0);
    wait_done(0, n);
    check("b2b_lat", 32'(n), 32'd5);
    check("b2b_res", get_result(0), 32'h0F00);

    // flush together with start while idle: not accepted, no err
    flush   = 1'b1;
    start_b = 1'b1;
    tick();
    flush   = 1'b0;
    start_b = 1'b0;
    check("flush_start_busy", get_busy(1), 32'd0);
    check("flush_start_err",  get_err(1),  32'd0);

    // flush three edges into an srl
    go(0, M_SRL, 16'hFFFF, 5'd10);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", get_busy(0), 32'd0);
    check("flush_done", get_done(0), 32'd0);
    dones = 0;
    repeat (12) begin
      tick();
      if (done_a) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_res",     get_result(0), 32'h0F00);

    // asynchronous reset mid-operation, checked before any further edge
    go(0, M_SLL, 16'h0001, 5'd8);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_busy",   get_busy(0),   32'd0);
    check("areset_done",   get_done(0),   32'd0);
    check("areset_result", get_result(0), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_shift_unit.md
Name: multicycle_shift_unit

Overview:
Parametrised iterative shift/rotate unit for the MIPS datapath. It generalises the single-cycle sll path to logical, arithmetic and rotate modes of any width. Throughput is configurable in bits per cycle, and a start/busy/done handshake lets the control unit stall while the shift runs. It sits beside the ALU and takes operands from the register file read ports (rt value, shamt field).

Parameters:
DATA_W, 16, operand/result width in bits (>=2).
SHAMT_W, 4, width of shift-amount input.
STEP, 1, maximum bits shifted per cycle; power of two, 1..DATA_W.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  request; accepted on a rising edge when busy=0.
flush  input  1  synchronous abort of the operation in flight.
mode  input  3  000 sll, 001 srl, 010 sra, 011 rol, 100 ror, 101-111 illegal.
shamt  input  SHAMT_W  requested shift amount (unsigned).
data_in  input  DATA_W  operand.
busy  output  1  operation in flight; start ignored while high.
done  output  1  one-cycle pulse; result valid from this cycle on.
result  output  DATA_W  last completed result, held until the next done.
err  output  1  one-cycle pulse: start while busy, or illegal mode accepted.

Behaviour:
- Reset (async, reset_n=0): busy=0, done=0, err=0, result=0. Internal accumulator and remaining-count are cleared. An operation in flight is abandoned with no done.
- Effective amount E, latched at accept:
  - sll/srl: min(shamt, DATA_W).
  - sra: min(shamt, DATA_W-1).
  - rol/ror: shamt mod DATA_W.
  - illegal mode: 0.
- Accept edge (start=1, busy=0, flush=0): acc<=data_in, rem<=E, mode latched, busy<=1. err<=1 if mode is illegal.
- Each edge with busy=1 and flush=0:
  - If rem=0: busy<=0, done<=1, result<=acc.
  - Else: shift acc by s=min(STEP, rem) in the latched mode and set rem<=rem-s.
  - Fill rules: sll/srl fill 0; sra replicates acc[DATA_W-1]; rotates wrap the bits around.
- Latency: done is high in the cycle following edge k+ceil(E/STEP)+1, where k is the accept edge. E=0 gives done after 1 further edge.
- done and err are high for exactly one cycle, otherwise 0. result changes only on the done edge.
- start while busy=1: ignored and err<=1 for one cycle; the operation in flight is unaffected.
- Start in the done cycle: busy is already 0, so the request is accepted on the next edge. Back-to-back operation has no bubble beyond the rem=0 edge.
- flush=1 on an edge: busy<=0, rem<=0, no done, result unchanged. flush with start on the same edge: flush wins and start is not accepted (no err).
- Illegal mode completes as a pass-through: result=data_in, with done after 1 edge.
- Operands are sampled only on the accept edge; later changes to data_in, shamt or mode have no effect.

Test Plan:
1. DATA_W=16, STEP=1: sll, data_in=0x0001, shamt=4 -> busy for 5 cycles, done pulse, result=0x0010, err=0.
2. STEP=4: sra 0x8000 shamt=15 -> done 5 cycles after accept, result=0xFFFF. srl 0x8000 shamt=15 -> 0x0001.
3. STEP=4: ror 0x1234 shamt=4 -> 0x4123 after 2 cycles. STEP=1: rol 0x8001 shamt=1 -> 0x0003.
4. SHAMT_W=5: srl 0xFFFF shamt=20 -> 0x0000. ror 0x1234 shamt=20 -> 0x4123 (E=4). Illegal mode 110 -> err pulse, result=data_in.
5. start pulsed twice during a busy sll (shamt=8, STEP=1) -> two err pulses, single done, result=data_in<<8. New start in the done cycle -> accepted, second done with correct value.
6. flush 3 cycles into an srl (shamt=10) -> busy low next cycle, no done, result keeps prior value. reset_n low mid-op -> busy/done/result=0 immediately, no clock required.
